// File: rtl/bp_stream_mmio_arbiter.sv
// Shares one host stream link between several MMIO requesters.
// Outbound packets are granted round-robin and locked; read responses are routed back in issue order.
module bp_stream_mmio_arbiter #(
    parameter int num_req_p           = 2,
    parameter int stream_data_width_p = 32,
    parameter int pkt_words_p         = 2,
    parameter int resp_words_p        = 2,
    parameter int order_els_p         = 16
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic [num_req_p-1:0]                       req_v_i,
    input  logic [num_req_p*stream_data_width_p-1:0]   req_data_i,
    input  logic [num_req_p-1:0]                       req_rd_i,
    output logic [num_req_p-1:0]                       req_yumi_o,
    output logic                                       stream_v_o,
    output logic [stream_data_width_p-1:0]             stream_data_o,
    input  logic                                       stream_yumi_i,
    input  logic                                       stream_v_i,
    input  logic [stream_data_width_p-1:0]             stream_data_i,
    output logic                                       stream_ready_o,
    output logic [num_req_p-1:0]                       resp_v_o,
    output logic [stream_data_width_p-1:0]             resp_data_o,
    input  logic [num_req_p-1:0]                       resp_ready_i,
    output logic [$clog2(order_els_p+1)-1:0]           outstanding_o
);

    localparam int sel_w_lp  = $clog2(num_req_p);
    localparam int cnt_w_lp  = $clog2(order_els_p+1);
    localparam int ptr_w_lp  = (order_els_p > 1) ? $clog2(order_els_p) : 1;
    localparam int word_w_lp = $clog2(pkt_words_p+1);
    localparam int beat_w_lp = $clog2(resp_words_p+1);

    typedef logic [sel_w_lp-1:0] sel_t;
    typedef logic [ptr_w_lp-1:0] ptr_t;
    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                 state_r, state_n;
    sel_t                   grant_r, rr_r, sel;
    logic [word_w_lp-1:0]   word_cnt_r;
    logic [beat_w_lp-1:0]   beat_cnt_r;
    ptr_t                   wptr_r, rptr_r;
    logic [cnt_w_lp-1:0]    count_r;
    sel_t                   tags_r [order_els_p];

    logic [num_req_p-1:0]   eligible;
    logic                   sel_found, fifo_full, fifo_ne;
    logic                   out_hs, first_hs, last_word, push, pop, in_hs;
    sel_t                   head;

    function automatic sel_t rr_next(input sel_t s);
        return (s == sel_t'(num_req_p-1)) ? '0 : s + sel_t'(1);
    endfunction

    function automatic ptr_t ptr_next(input ptr_t p);
        return (p == ptr_t'(order_els_p-1)) ? '0 : p + ptr_t'(1);
    endfunction

    // full is taken from the registered count, so a same-cycle pop never frees a slot early
    assign fifo_full = (count_r == cnt_w_lp'(order_els_p));
    assign fifo_ne   = (count_r != '0);
    assign head      = tags_r[rptr_r];

    always_comb begin
        for (int i = 0; i < num_req_p; i++)
            eligible[i] = req_v_i[i] & (~req_rd_i[i] | ~fifo_full);
    end

    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        for (int k = 0; k < num_req_p; k++) begin
            if (!sel_found && eligible[(int'(rr_r) + k) % num_req_p]) begin
                sel_found = 1'b1;
                sel       = sel_t'((int'(rr_r) + k) % num_req_p);
            end
        end
    end

    assign out_hs    = stream_v_o & stream_yumi_i;
    assign first_hs  = (state_r == IDLE) & out_hs;
    assign last_word = (state_r == LOCKED) & out_hs & (word_cnt_r == word_w_lp'(pkt_words_p-1));
    assign push      = first_hs & req_rd_i[sel];
    assign in_hs     = stream_v_i & stream_ready_o;
    assign pop       = in_hs & (beat_cnt_r == beat_w_lp'(resp_words_p-1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= IDLE;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:    if (first_hs && (pkt_words_p > 1)) state_n = LOCKED;
            LOCKED:  if (last_word) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are forced low while reset is asserted, since most of them are combinational paths from inputs
    always_comb begin
        stream_v_o     = 1'b0;
        stream_data_o  = '0;
        req_yumi_o     = '0;
        stream_ready_o = 1'b0;
        resp_v_o       = '0;
        resp_data_o    = '0;
        outstanding_o  = '0;
        if (!reset_i) begin
            case (state_r)
                IDLE: begin
                    if (sel_found) begin
                        stream_v_o      = 1'b1;
                        stream_data_o   = req_data_i[int'(sel)*stream_data_width_p +: stream_data_width_p];
                        req_yumi_o[sel] = stream_yumi_i;
                    end
                end
                LOCKED: begin
                    stream_v_o          = req_v_i[grant_r];
                    stream_data_o       = req_data_i[int'(grant_r)*stream_data_width_p +: stream_data_width_p];
                    req_yumi_o[grant_r] = stream_yumi_i & req_v_i[grant_r];
                end
                default: ;
            endcase
            stream_ready_o = fifo_ne & resp_ready_i[head];
            resp_v_o[head] = stream_v_i & fifo_ne;
            resp_data_o    = stream_data_i;
            outstanding_o  = count_r;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            grant_r    <= '0;
            rr_r       <= '0;
            word_cnt_r <= '0;
        end else if (first_hs) begin
            grant_r <= sel;
            if (pkt_words_p > 1) begin
                word_cnt_r <= word_w_lp'(1);
            end else begin
                word_cnt_r <= '0;
                rr_r       <= rr_next(sel);
            end
        end else if (last_word) begin
            rr_r       <= rr_next(grant_r);
            word_cnt_r <= '0;
        end else if ((state_r == LOCKED) && out_hs) begin
            word_cnt_r <= word_cnt_r + word_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_r     <= '0;
            rptr_r     <= '0;
            count_r    <= '0;
            beat_cnt_r <= '0;
        end else begin
            if (push) wptr_r <= ptr_next(wptr_r);
            if (pop)  rptr_r <= ptr_next(rptr_r);
            case ({push, pop})
                2'b10:   count_r <= count_r + cnt_w_lp'(1);
                2'b01:   count_r <= count_r - cnt_w_lp'(1);
                default: count_r <= count_r;
            endcase
            if (pop)        beat_cnt_r <= '0;
            else if (in_hs) beat_cnt_r <= beat_cnt_r + beat_w_lp'(1);
        end
    end

    // Tag storage holds only data, so it carries no reset
    always_ff @(posedge clk_i) begin
        if (push) tags_r[wptr_r] <= sel;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i && stream_yumi_i) assert (stream_v_o);
    end
`endif

endmodule

// File: tb/tb_bp_stream_mmio_arbiter.sv
// Directed bench for bp_stream_mmio_arbiter: a per-cycle vector table plus hand sequences
// for the tag-FIFO-full stall and reset in the middle of a locked packet.
module tb_bp_stream_mmio_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [1:0]  req_v_i, req_rd_i, req_yumi_o, resp_v_o, resp_ready_i;
    logic [63:0] req_data_i;
    logic        stream_v_o, stream_yumi_i, stream_v_i, stream_ready_o;
    logic [31:0] stream_data_o, stream_data_i, resp_data_o;
    logic [4:0]  outstanding_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    bp_stream_mmio_arbiter dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_v_i(req_v_i), .req_data_i(req_data_i), .req_rd_i(req_rd_i), .req_yumi_o(req_yumi_o),
        .stream_v_o(stream_v_o), .stream_data_o(stream_data_o), .stream_yumi_i(stream_yumi_i),
        .stream_v_i(stream_v_i), .stream_data_i(stream_data_i), .stream_ready_o(stream_ready_o),
        .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_ready_i(resp_ready_i),
        .outstanding_o(outstanding_o)
    );

    typedef struct {
        logic [1:0]  rv, rd;
        logic [31:0] d0, d1;
        logic        yumi, sv;
        logic [31:0] sd;
        logic [1:0]  rr;
        logic        ev, cd;
        logic [31:0] ed;
        logic [1:0]  eyumi;
        logic        erdy;
        logic [1:0]  erv;
        logic [4:0]  eout;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic [1:0] rv, input logic [1:0] rd, input logic [31:0] d0,
                                input logic [31:0] d1, input logic yumi, input logic sv,
                                input logic [31:0] sd, input logic [1:0] rr, input logic ev,
                                input logic cd, input logic [31:0] ed, input logic [1:0] eyumi,
                                input logic erdy, input logic [1:0] erv, input logic [4:0] eout);
        vec_t v;
        v.rv = rv; v.rd = rd; v.d0 = d0; v.d1 = d1; v.yumi = yumi; v.sv = sv; v.sd = sd; v.rr = rr;
        v.ev = ev; v.cd = cd; v.ed = ed; v.eyumi = eyumi; v.erdy = erdy; v.erv = erv; v.eout = eout;
        return v;
    endfunction

    task automatic apply(input logic [1:0] rv, input logic [1:0] rd, input logic [31:0] d0,
                         input logic [31:0] d1, input logic yumi, input logic sv,
                         input logic [31:0] sd, input logic [1:0] rr);
        req_v_i = rv; req_rd_i = rd; req_data_i = {d1, d0}; stream_yumi_i = yumi;
        stream_v_i = sv; stream_data_i = sd; resp_ready_i = rr;
    endtask

    task automatic fail(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        n_err++;
        $display("FAIL %s %s: got %h, required %h", nm, fld, act, req);
    endtask

    task automatic check_outs(input string nm, input logic ev, input logic cd, input logic [31:0] ed,
                              input logic [1:0] eyumi, input logic erdy, input logic [1:0] erv,
                              input logic [4:0] eout, input logic [31:0] erdata);
        n_vec++;
        if (stream_v_o !== ev)                 fail(nm, "stream_v_o", 32'(stream_v_o), 32'(ev));
        if (cd && (stream_data_o !== ed))      fail(nm, "stream_data_o", stream_data_o, ed);
        if (req_yumi_o !== eyumi)              fail(nm, "req_yumi_o", 32'(req_yumi_o), 32'(eyumi));
        if (stream_ready_o !== erdy)           fail(nm, "stream_ready_o", 32'(stream_ready_o), 32'(erdy));
        if (resp_v_o !== erv)                  fail(nm, "resp_v_o", 32'(resp_v_o), 32'(erv));
        if (outstanding_o !== eout)            fail(nm, "outstanding_o", 32'(outstanding_o), 32'(eout));
        if ((erv != 2'b00) && (resp_data_o !== erdata)) fail(nm, "resp_data_o", resp_data_o, erdata);
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // write packet from req0, then rr=1 favours req1
        vt.push_back(mk(2'b01, 2'b00, 32'h8000_0010, 0, 1, 0, 0, 2'b11, 1, 1, 32'h8000_0010, 2'b01, 0, 2'b00, 0));
        vt.push_back(mk(2'b01, 2'b00, 32'hDEAD_BEEF, 0, 1, 0, 0, 2'b11, 1, 1, 32'hDEAD_BEEF, 2'b01, 0, 2'b00, 0));
        vt.push_back(mk(2'b11, 2'b00, 32'hA000_0000, 32'hB000_0000, 0, 0, 0, 2'b11, 1, 1, 32'hB000_0000, 2'b00, 0, 2'b00, 0));
        vt.push_back(mk(2'b11, 2'b00, 32'hA000_0000, 32'hB000_0000, 1, 0, 0, 2'b11, 1, 1, 32'hB000_0000, 2'b10, 0, 2'b00, 0));
        vt.push_back(mk(2'b11, 2'b00, 32'hA000_0000, 32'hB000_0001, 1, 0, 0, 2'b11, 1, 1, 32'hB000_0001, 2'b10, 0, 2'b00, 0));
        // contention: req0 wins at rr=0, bubbles 3 cycles, req1 must wait
        vt.push_back(mk(2'b11, 2'b00, 32'hA000_0000, 32'hB000_0000, 1, 0, 0, 2'b11, 1, 1, 32'hA000_0000, 2'b01, 0, 2'b00, 0));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(2'b10, 2'b00, 32'hA000_0001, 32'hB000_0000, 0, 0, 0, 2'b11, 0, 0, 0, 2'b00, 0, 2'b00, 0));
        vt.push_back(mk(2'b11, 2'b00, 32'hA000_0001, 32'hB000_0000, 1, 0, 0, 2'b11, 1, 1, 32'hA000_0001, 2'b01, 0, 2'b00, 0));
        vt.push_back(mk(2'b10, 2'b00, 0, 32'hB000_0000, 1, 0, 0, 2'b11, 1, 1, 32'hB000_0000, 2'b10, 0, 2'b00, 0));
        vt.push_back(mk(2'b10, 2'b00, 0, 32'hB000_0001, 1, 0, 0, 2'b11, 1, 1, 32'hB000_0001, 2'b10, 0, 2'b00, 0));
        // req1 read then req0 read, responses routed in order
        vt.push_back(mk(2'b10, 2'b10, 0, 32'hC000_0000, 1, 0, 0, 2'b11, 1, 1, 32'hC000_0000, 2'b10, 0, 2'b00, 0));
        vt.push_back(mk(2'b10, 2'b00, 0, 32'hC000_0001, 1, 0, 0, 2'b11, 1, 1, 32'hC000_0001, 2'b10, 1, 2'b00, 1));
        vt.push_back(mk(2'b01, 2'b01, 32'hD000_0000, 0, 1, 0, 0, 2'b11, 1, 1, 32'hD000_0000, 2'b01, 1, 2'b00, 1));
        vt.push_back(mk(2'b01, 2'b00, 32'hD000_0001, 0, 1, 0, 0, 2'b11, 1, 1, 32'hD000_0001, 2'b01, 1, 2'b00, 2));
        vt.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 32'h1111_1111, 2'b11, 0, 0, 0, 2'b00, 1, 2'b10, 2));
        vt.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 32'h2222_2222, 2'b11, 0, 0, 0, 2'b00, 1, 2'b10, 2));
        vt.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 32'h3333_3333, 2'b11, 0, 0, 0, 2'b00, 1, 2'b01, 1));
        vt.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 32'h4444_4444, 2'b11, 0, 0, 0, 2'b00, 1, 2'b01, 1));
        vt.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 2'b00, 0, 2'b00, 0));
        // backpressure on the head requester, then orphan word with empty FIFO
        vt.push_back(mk(2'b10, 2'b10, 0, 32'hE000_0000, 1, 0, 0, 2'b11, 1, 1, 32'hE000_0000, 2'b10, 0, 2'b00, 0));
        vt.push_back(mk(2'b10, 2'b00, 0, 32'hE000_0001, 1, 0, 0, 2'b11, 1, 1, 32'hE000_0001, 2'b10, 1, 2'b00, 1));
        vt.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 32'h5555_5555, 2'b01, 0, 0, 0, 2'b00, 0, 2'b10, 1));
        vt.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 32'h5555_5555, 2'b01, 0, 0, 0, 2'b00, 0, 2'b10, 1));
        vt.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 32'h5555_5555, 2'b11, 0, 0, 0, 2'b00, 1, 2'b10, 1));
        vt.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 32'h6666_6666, 2'b11, 0, 0, 0, 2'b00, 1, 2'b10, 1));
        vt.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 32'h7777_7777, 2'b11, 0, 0, 0, 2'b00, 0, 2'b00, 0));

        // reset state with busy-looking inputs
        reset_i = 1'b1;
        apply(2'b11, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1, 32'h0BAD_0BAD, 2'b11);
        #2;
        check_outs("reset_state", 0, 1, 0, 2'b00, 0, 2'b00, 0, 0);
        if (resp_data_o !== 32'h0) fail("reset_state", "resp_data_o", resp_data_o, 0);
        step();
        reset_i = 1'b0;
        apply(2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b11);

        foreach (vt[i]) begin
            step();
            apply(vt[i].rv, vt[i].rd, vt[i].d0, vt[i].d1, vt[i].yumi, vt[i].sv, vt[i].sd, vt[i].rr);
            #2;
            check_outs($sformatf("vec%0d", i), vt[i].ev, vt[i].cd, vt[i].ed, vt[i].eyumi,
                       vt[i].erdy, vt[i].erv, vt[i].eout, vt[i].sd);
        end

        // fill the tag FIFO with 16 reads from req0
        for (int i = 0; i < 16; i++) begin
            step();
            apply(2'b01, 2'b01, 32'h9000_0000 + i, 0, 1, 0, 0, 2'b11);
            #2;
            check_outs($sformatf("fill%0d_w0", i), 1, 1, 32'h9000_0000 + i, 2'b01, (i != 0), 2'b00, 5'(i), 0);
            step();
            apply(2'b01, 2'b00, 32'h9100_0000 + i, 0, 1, 0, 0, 2'b11);
            #2;
            check_outs($sformatf("fill%0d_w1", i), 1, 1, 32'h9100_0000 + i, 2'b01, 1, 2'b00, 5'(i + 1), 0);
        end
        // full: req0 read stalled, req1 writes pass even when rr favours req0
        step(); apply(2'b11, 2'b01, 32'h9F00_0000, 32'hF100_0000, 1, 0, 0, 2'b11); #2;
        check_outs("full_wr1_w0", 1, 1, 32'hF100_0000, 2'b10, 1, 2'b00, 16, 0);
        step(); apply(2'b11, 2'b01, 32'h9F00_0000, 32'hF100_0001, 1, 0, 0, 2'b11); #2;
        check_outs("full_wr1_w1", 1, 1, 32'hF100_0001, 2'b10, 1, 2'b00, 16, 0);
        step(); apply(2'b11, 2'b01, 32'h9F00_0000, 32'hF200_0000, 1, 0, 0, 2'b11); #2;
        check_outs("full_wr2_w0", 1, 1, 32'hF200_0000, 2'b10, 1, 2'b00, 16, 0);
        step(); apply(2'b11, 2'b01, 32'h9F00_0000, 32'hF200_0001, 1, 0, 0, 2'b11); #2;
        check_outs("full_wr2_w1", 1, 1, 32'hF200_0001, 2'b10, 1, 2'b00, 16, 0);
        step(); apply(2'b01, 2'b01, 32'h9F00_0000, 0, 0, 0, 0, 2'b11); #2;
        check_outs("full_stall", 0, 0, 0, 2'b00, 1, 2'b00, 16, 0);
        step(); apply(2'b01, 2'b01, 32'h9F00_0000, 0, 0, 1, 32'hAAAA_0001, 2'b11); #2;
        check_outs("full_resp_b0", 0, 0, 0, 2'b00, 1, 2'b01, 16, 32'hAAAA_0001);
        step(); apply(2'b01, 2'b01, 32'h9F00_0000, 0, 0, 1, 32'hAAAA_0002, 2'b11); #2;
        check_outs("full_pop_cycle", 0, 0, 0, 2'b00, 1, 2'b01, 16, 32'hAAAA_0002);
        step(); apply(2'b01, 2'b01, 32'h9F00_0000, 0, 1, 0, 0, 2'b11); #2;
        check_outs("unstall_w0", 1, 1, 32'h9F00_0000, 2'b01, 1, 2'b00, 15, 0);
        step(); apply(2'b01, 2'b00, 32'h9F00_0001, 0, 1, 0, 0, 2'b11); #2;
        check_outs("unstall_w1", 1, 1, 32'h9F00_0001, 2'b01, 1, 2'b00, 16, 0);

        // reset in the middle of a locked packet
        step(); apply(2'b10, 2'b00, 0, 32'hC500_0000, 1, 1, 32'hBBBB_0000, 2'b11); #2;
        check_outs("pre_reset_w0", 1, 1, 32'hC500_0000, 2'b10, 1, 2'b01, 16, 32'hBBBB_0000);
        step();
        apply(2'b10, 2'b00, 0, 32'hC500_0001, 0, 1, 32'hBBBB_0001, 2'b11);
        reset_i = 1'b1;
        #1;
        check_outs("mid_lock_reset", 0, 1, 0, 2'b00, 0, 2'b00, 0, 0);
        if (resp_data_o !== 32'h0) fail("mid_lock_reset", "resp_data_o", resp_data_o, 0);
        step();
        reset_i = 1'b0;
        apply(2'b11, 2'b00, 32'hA500_0000, 32'hC500_0001, 0, 1, 32'hBBBB_0001, 2'b11);
        #2;
        check_outs("post_reset_rr0", 1, 1, 32'hA500_0000, 2'b00, 0, 2'b00, 0, 0);

        step();
        apply(2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
